trng_axi_reader: RTL
====================

Name: trng_axi_reader

Overview:
AXI4-Lite read initiator that polls the TRNG data register (random byte in RDATA[7:0]) over the read address/data channels.
- Packs 4 consecutive random bytes into one 32-bit word.
- Presents each word on a valid/ready stream to downstream consumers (DMA staging, self-test logic).
- Runs a software-programmed number of words per start pulse.

Parameters:
TRNG_ADDR, 32'h0000_0000, byte address of the TRNG data register driven on M_AXI_ARADDR
BYTES_PER_WORD, 4, bytes packed per output word (fixed 4; word width 32)
TIMEOUT_CYCLES, 255, max cycles waiting for RVALID (used only with the optional feature)

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
req_words  in  8  words to collect this run; sampled on start
M_AXI_ARADDR  out  32  read address, constant TRNG_ADDR
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address accepted
M_AXI_RDATA  in  32  read data; only [7:0] used
M_AXI_RRESP  in  2  read response; 2'b00 = OKAY
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
word_data  out  32  packed random word
word_valid  out  1  word available
word_ready  in  1  consumer accepts word
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run (normal or aborted)
err  out  1  sticky: non-OKAY RRESP (or timeout); cleared by next accepted start

Behaviour:
- Reset (async, ARESETN low) values:
  - ARVALID = 0, RREADY = 0, word_valid = 0, word_data = 0, busy = 0, done = 0, err = 0.
  - M_AXI_ARADDR is tied to TRNG_ADDR at all times.
  - Internal byte count and word count reset to 0; FSM goes to IDLE.
- FSM states: IDLE, ADDR, DATA, OUT.
- IDLE:
  - On start: latch req_words, clear err, clear byte and word counters.
  - If req_words == 0: pulse done the next cycle and stay IDLE; no AXI traffic.
  - Otherwise go to ADDR; busy = 1 from the next cycle.
  - start is ignored in any state other than IDLE.
- ADDR:
  - ARVALID = 1, held until the cycle ARREADY = 1, then DATA. ARVALID never deasserts without a handshake.
  - First ARVALID appears 1 cycle after start.
- DATA:
  - RREADY = 1.
  - On RVALID with RRESP = OKAY: byte k of the current word (k = 0..3, arrival order) goes to word_data[8k+7:8k]; increment byte count.
    - k == 3: go to OUT.
    - Otherwise: go to ADDR (next read issued the following cycle).
  - On RVALID with RRESP != OKAY: set err, drop partial word, pulse done, go to IDLE.
- OUT:
  - word_valid = 1; word_data stable until the word_ready handshake.
  - On handshake, increment word count and deassert word_valid.
  - If word count == req_words: pulse done, go to IDLE.
  - Otherwise go to ADDR.
- No overlap: at most one outstanding read. No new read is issued while a word is pending in OUT (backpressure stalls the bus).
- Word-count arithmetic is 8-bit; req_words = 255 produces exactly 255 words with no wrap.
- busy = 1 in ADDR, DATA and OUT; busy = 0 in IDLE, including the done cycle.
- Reset mid-run: everything returns to reset values immediately and the partial word is lost. The interconnect is reset by the same ARESETN.

Optional Feature:
TRNG_RD_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs in DATA and clears on entry to DATA.
  - If it reaches TIMEOUT_CYCLES without RVALID: set err, pulse done, go to IDLE.
  - Software must reset the interconnect before the next run.
- Undefined: DATA waits for RVALID indefinitely; no counter is synthesized.

Decomposition:
- Shared package trng_pkg:
  - FSM state encodings (IDLE/ADDR/DATA/OUT)
  - RESP_OKAY = 2'b00
  - BYTES_PER_WORD
  - default TRNG_ADDR
- One natural sub-module: trng_byte_packer.
  - Shift/insert register plus 2-bit byte counter.
  - Inputs: byte_in, load, clear.
  - Outputs: word, full.

Test Plan:
- start with req_words = 1, ARREADY always 1, RVALID 1 cycle after each ARREADY, bytes 0x11, 0x22, 0x33, 0x44 → word_data = 32'h44332211, 4 AR handshakes, done pulse after the word_ready handshake.
- req_words = 0 → done pulses 1 cycle after start, ARVALID never asserted, busy stays 0.
- ARREADY held low 5 cycles → ARVALID held high all 5 cycles, then one handshake; word_ready held low 10 cycles → no ARVALID during OUT, word_data stable.
- RRESP = 2'b10 on the 3rd byte → err = 1, done pulse, word_valid never asserted; next start clears err.
- TRNG_RD_TIMEOUT_EN defined, RVALID never asserted → err and done after 255 DATA cycles; undefined → busy stays 1.
- ARESETN low during DATA with 2 bytes packed → all outputs 0 immediately; next run with req_words = 2 yields 2 clean words.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG AXI4-Lite reader: FSM encoding, AXI response
// code, word geometry and the default TRNG data register address.
package trng_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StOut  = 2'd3
    } trng_state_e;

    localparam logic [1:0]  RESP_OKAY         = 2'b00;
    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam logic [31:0] TRNG_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/trng_byte_packer.sv
// Byte packer: inserts arriving bytes into a 32-bit word in arrival order
// (byte k lands in bits [8k+7:8k]) and flags the load that completes the word.
module trng_byte_packer #(
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        load,
    input  logic        clear,
    output logic [31:0] word,
    output logic        full
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;

    // full is asserted together with the load that fills the last byte lane
    assign full = load && (byte_cnt_q == LAST_IDX);
    assign word = word_q;

    // Insert register and byte counter; the counter wraps to 0 after a full word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else if (clear) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else if (load) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_in;
            byte_cnt_q                        <= byte_cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/trng_axi_reader.sv
// AXI4-Lite read initiator polling the TRNG data register. Four random bytes are
// packed per 32-bit word and offered on a valid/ready stream; a run produces
// req_words words per start pulse with at most one read outstanding.
// Optional build macro TRNG_RD_TIMEOUT_EN adds an RVALID wait timeout.
module trng_axi_reader
    import trng_pkg::*;
#(
    parameter logic [31:0] TRNG_ADDR      = TRNG_ADDR_DEFAULT,
    parameter int unsigned BYTES_PER_WORD = trng_pkg::BYTES_PER_WORD,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        start,
    input  logic [7:0]  req_words,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    trng_state_e state_q;
    logic [7:0]  req_q;
    logic [7:0]  word_cnt_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        word_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        r_hs;
    logic        r_ok;
    logic        rd_abort;
    logic        to_hit;
    logic        pk_load;
    logic        pk_clear;
    logic        pk_full;
    logic [31:0] pk_word;

    // Only the low byte of RDATA carries entropy
    logic        unused_rdata;
    assign unused_rdata = ^M_AXI_RDATA[31:8];

    assign r_hs     = (state_q == StData) && M_AXI_RVALID;
    assign r_ok     = (M_AXI_RRESP == RESP_OKAY);
    assign pk_load  = r_hs && r_ok;
    assign rd_abort = (r_hs && !r_ok) || to_hit;
    // A new run or an aborted read discards any partial word
    assign pk_clear = ((state_q == StIdle) && start) || rd_abort;

`ifdef TRNG_RD_TIMEOUT_EN
    logic [7:0] to_cnt_q;

    assign to_hit = (state_q == StData) && !M_AXI_RVALID &&
                    (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // RVALID wait counter; held at zero outside DATA so every entry starts fresh
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            to_cnt_q <= '0;
        end else if (state_q != StData) begin
            to_cnt_q <= '0;
        end else if (!M_AXI_RVALID) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_hit             = 1'b0;
`endif

    trng_byte_packer #(
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_packer (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .byte_in (M_AXI_RDATA[7:0]),
        .load    (pk_load),
        .clear   (pk_clear),
        .word    (pk_word),
        .full    (pk_full)
    );

    // Run controller with registered AXI and stream handshake outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= StIdle;
            req_q        <= '0;
            word_cnt_q   <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        req_q      <= req_words;
                        word_cnt_q <= '0;
                        err_q      <= 1'b0;
                        if (req_words == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= StAddr;
                            arvalid_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                StAddr: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (rd_abort) begin
                        rready_q <= 1'b0;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else if (pk_load) begin
                        rready_q <= 1'b0;
                        if (pk_full) begin
                            word_valid_q <= 1'b1;
                            state_q      <= StOut;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StAddr;
                        end
                    end
                end
                StOut: begin
                    if (word_ready) begin
                        word_valid_q <= 1'b0;
                        word_cnt_q   <= word_cnt_q + 8'd1;
                        if (word_cnt_q + 8'd1 == req_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StAddr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign M_AXI_ARADDR  = TRNG_ADDR;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign word_data     = pk_word;
    assign word_valid    = word_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
